// File: rtl/text_pixel_serializer.sv
// Text-mode pixel output stage: captures a glyph row and its attributes on load, then serialises
// the pixels to dac with blink and underrun tracking. Define TEXT_PIXEL_CURSOR_EN for cursor swap.
module text_pixel_serializer #(
  parameter int unsigned CHAR_WIDTH   = 8,
  parameter int unsigned COLOR_BITS   = 3,
  parameter int unsigned BLINK_FRAMES = 36,
  parameter int unsigned PIXEL_REPEAT = 1
) (
  input  logic                  clk,
  input  logic                  reset_button,
  input  logic                  frame_start,
  input  logic                  load,
  input  logic                  drawing,
  input  logic [CHAR_WIDTH-1:0] row_pixels,
  input  logic [COLOR_BITS-1:0] foreground,
  input  logic [COLOR_BITS-1:0] background,
  input  logic                  blink,
  input  logic                  invert,
`ifdef TEXT_PIXEL_CURSOR_EN
  input  logic                  cursor,
`endif
  output logic [COLOR_BITS-1:0] dac,
  output logic                  blinking,
  output logic                  underrun
);

  localparam int unsigned IdxW = $clog2(CHAR_WIDTH);
  localparam int unsigned RepW = (PIXEL_REPEAT > 1) ? $clog2(PIXEL_REPEAT) : 1;
  localparam int unsigned FrmW = $clog2(BLINK_FRAMES);

  localparam logic [IdxW-1:0] IdxLast = IdxW'(CHAR_WIDTH - 1);
  localparam logic [RepW-1:0] RepLast = RepW'(PIXEL_REPEAT - 1);
  localparam logic [FrmW-1:0] FrmLast = FrmW'(BLINK_FRAMES - 1);

  typedef enum logic [0:0] {StExhausted, StLoaded} cell_state_e;

  cell_state_e           state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [RepW-1:0]       rep_q, rep_d;
  logic [CHAR_WIDTH-1:0] row_q, row_d;
  logic [COLOR_BITS-1:0] fg_q, fg_d;
  logic [COLOR_BITS-1:0] bg_q, bg_d;
  logic                  blink_q, blink_d;
  logic                  inv_q, inv_d;
  logic [FrmW-1:0]       frame_q, frame_d;
  logic                  blinking_q, blinking_d;
  logic                  underrun_q, underrun_d;
  logic [COLOR_BITS-1:0] dac_q, dac_d;
  logic                  cell_end;
  logic                  pix_on;
  logic                  swap;
  logic [COLOR_BITS-1:0] fg_eff, bg_eff;

`ifdef TEXT_PIXEL_CURSOR_EN
  localparam logic [FrmW-1:0] FrmHalf = FrmW'(BLINK_FRAMES / 2 - 1);
  logic cursor_q, cursor_d;
  logic cphase_q, cphase_d;
`endif

  // Cell sequencing; a load always wins so back-to-back cells never gap.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rep_d    = rep_q;
    row_d    = row_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    blink_d  = blink_q;
    inv_d    = inv_q;
    cell_end = 1'b0;
`ifdef TEXT_PIXEL_CURSOR_EN
    cursor_d = cursor_q;
`endif
    if (load) begin
      state_d = StLoaded;
      idx_d   = '0;
      rep_d   = '0;
      row_d   = row_pixels;
      fg_d    = foreground;
      bg_d    = background;
      blink_d = blink;
      inv_d   = invert;
`ifdef TEXT_PIXEL_CURSOR_EN
      cursor_d = cursor;
`endif
    end else if (state_q == StLoaded) begin
      if (rep_q == RepLast) begin
        rep_d = '0;
        if (idx_q == IdxLast) begin
          state_d  = StExhausted;
          cell_end = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_comb begin
    frame_d    = frame_q;
    blinking_d = blinking_q;
`ifdef TEXT_PIXEL_CURSOR_EN
    cphase_d = cphase_q;
    if (frame_start && (frame_q == FrmHalf || frame_q == FrmLast)) begin
      cphase_d = ~cphase_q;
    end
`endif
    if (frame_start) begin
      if (frame_q == FrmLast) begin
        frame_d    = '0;
        blinking_d = ~blinking_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_comb begin
`ifdef TEXT_PIXEL_CURSOR_EN
    swap = cursor_q & cphase_q;
`else
    swap = 1'b0;
`endif
    fg_eff = swap ? bg_q : fg_q;
    bg_eff = swap ? fg_q : bg_q;
    pix_on = row_q[idx_q] ^ inv_q;
    if (blink_q && !blinking_q) begin
      pix_on = 1'b0;
    end
    if (state_q == StExhausted) begin
      pix_on = 1'b0;
    end
    dac_d      = drawing ? (pix_on ? fg_eff : bg_eff) : '0;
    underrun_d = underrun_q | (cell_end & drawing);
  end

  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      state_q    <= StExhausted;
      idx_q      <= '0;
      rep_q      <= '0;
      row_q      <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      blink_q    <= 1'b0;
      inv_q      <= 1'b0;
      frame_q    <= '0;
      blinking_q <= 1'b1;
      underrun_q <= 1'b0;
      dac_q      <= '0;
`ifdef TEXT_PIXEL_CURSOR_EN
      cursor_q   <= 1'b0;
      cphase_q   <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rep_q      <= rep_d;
      row_q      <= row_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      blink_q    <= blink_d;
      inv_q      <= inv_d;
      frame_q    <= frame_d;
      blinking_q <= blinking_d;
      underrun_q <= underrun_d;
      dac_q      <= dac_d;
`ifdef TEXT_PIXEL_CURSOR_EN
      cursor_q   <= cursor_d;
      cphase_q   <= cphase_d;
`endif
    end
  end

  assign dac      = dac_q;
  assign blinking = blinking_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_text_pixel_serializer.sv
// Bench for text_pixel_serializer: two instances (pixel repeat 1 and 2) checked every cycle
// against a cycle-count model, plus directed literal expectations.
module tb_text_pixel_serializer;

  localparam int CW = 8;
  localparam int BF = 4;

  logic       clk = 1'b0;
  logic       reset_button = 1'b0;
  logic       frame_start = 1'b0;
  logic       load = 1'b0;
  logic       drawing = 1'b0;
  logic [7:0] row_pixels = '0;
  logic [2:0] foreground = '0;
  logic [2:0] background = '0;
  logic       blink = 1'b0;
  logic       invert = 1'b0;
`ifdef TEXT_PIXEL_CURSOR_EN
  logic       cursor = 1'b0;
`endif
  logic [2:0] dac0, dac1;
  logic       blinking0, blinking1, und0, und1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  text_pixel_serializer #(
    .CHAR_WIDTH(CW), .COLOR_BITS(3), .BLINK_FRAMES(BF), .PIXEL_REPEAT(1)
  ) u_dut0 (
    .clk(clk), .reset_button(reset_button), .frame_start(frame_start), .load(load),
    .drawing(drawing), .row_pixels(row_pixels), .foreground(foreground),
    .background(background), .blink(blink), .invert(invert),
`ifdef TEXT_PIXEL_CURSOR_EN
    .cursor(cursor),
`endif
    .dac(dac0), .blinking(blinking0), .underrun(und0)
  );

  text_pixel_serializer #(
    .CHAR_WIDTH(CW), .COLOR_BITS(3), .BLINK_FRAMES(BF), .PIXEL_REPEAT(2)
  ) u_dut1 (
    .clk(clk), .reset_button(reset_button), .frame_start(frame_start), .load(load),
    .drawing(drawing), .row_pixels(row_pixels), .foreground(foreground),
    .background(background), .blink(blink), .invert(invert),
`ifdef TEXT_PIXEL_CURSOR_EN
    .cursor(cursor),
`endif
    .dac(dac1), .blinking(blinking1), .underrun(und1)
  );

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp_v);
    end
  endtask

  // Model: cycles since the last load, total frame pulses since reset.
  logic       m_have = 1'b0;
  logic [7:0] m_row = '0;
  logic [2:0] m_fg = '0, m_bg = '0;
  logic       m_blink = 1'b0, m_inv = 1'b0, m_cur = 1'b0;
  int         m_off = 0;
  int         m_frames = 0;
  logic       m_und [2] = '{1'b0, 1'b0};
  logic [2:0] e_dac [2] = '{3'd0, 3'd0};
  logic       e_und [2] = '{1'b0, 1'b0};
  logic       e_blinking = 1'b1;
  int         m_pr;
  logic       m_on, m_vis, m_cph;
  logic [2:0] m_col, m_fgx, m_bgx;

  logic [2:0] log0 [4096];
  logic [2:0] log1 [4096];
  logic       logb [4096];
  logic       logu [4096];

  always @(negedge clk) begin
    log0[cyc[11:0]] = dac0;
    log1[cyc[11:0]] = dac1;
    logb[cyc[11:0]] = blinking0;
    logu[cyc[11:0]] = und0;
    if (!reset_button) begin
      m_have = 1'b0; m_row = '0; m_fg = '0; m_bg = '0;
      m_blink = 1'b0; m_inv = 1'b0; m_cur = 1'b0;
      m_off = 0; m_frames = 0;
      for (int i = 0; i < 2; i++) begin
        m_und[i] = 1'b0; e_und[i] = 1'b0; e_dac[i] = '0;
      end
      e_blinking = 1'b1;
    end
    chk("dac0", dac0, e_dac[0]);
    chk("dac1", dac1, e_dac[1]);
    chk("blinking0", blinking0, e_blinking);
    chk("blinking1", blinking1, e_blinking);
    chk("underrun0", und0, e_und[0]);
    chk("underrun1", und1, e_und[1]);
    if (reset_button) begin
      m_vis = ((m_frames / BF) % 2) == 0;
      m_cph = ((m_frames / (BF / 2)) % 2) == 0;
      for (int i = 0; i < 2; i++) begin
        m_pr  = i + 1;
        m_fgx = (m_cur && m_cph) ? m_bg : m_fg;
        m_bgx = (m_cur && m_cph) ? m_fg : m_bg;
        if (m_have && m_off < CW * m_pr) begin
          m_on = m_row[m_off / m_pr] ^ m_inv;
          if (m_blink && !m_vis) m_on = 1'b0;
          m_col = m_on ? m_fgx : m_bgx;
        end else begin
          m_col = m_bgx;
        end
        e_dac[i] = drawing ? m_col : 3'd0;
        if (m_have && m_off == CW * m_pr - 1 && drawing && !load) m_und[i] = 1'b1;
        e_und[i] = m_und[i];
      end
      if (load) begin
        m_have = 1'b1; m_off = 0; m_row = row_pixels; m_fg = foreground; m_bg = background;
        m_blink = blink; m_inv = invert;
`ifdef TEXT_PIXEL_CURSOR_EN
        m_cur = cursor;
`endif
      end else if (m_off < 100000) begin
        m_off++;
      end
      if (frame_start) m_frames++;
      e_blinking = ((m_frames / BF) % 2) == 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_button = 1'b0;
    load = 1'b0; frame_start = 1'b0; blink = 1'b0; invert = 1'b0; drawing = 1'b0;
    step();
    step();
    reset_button = 1'b1;
  endtask

  task automatic load_at(input logic [7:0] r, input logic [2:0] fg, input logic [2:0] bg,
                         input logic bl, input logic inv, output int l);
    row_pixels = r; foreground = fg; background = bg; blink = bl; invert = inv;
    load = 1'b1;
    l = cyc;
    step();
    load = 1'b0;
  endtask

  int L, L0, base;
  int t1e [8] = '{6, 1, 6, 1, 1, 1, 1, 1};

  initial begin
    step();
    step();
    reset_button = 1'b1;
    chk("reset_dac", dac0, 0);
    chk("reset_blinking", blinking0, 1);
    chk("reset_underrun", und0, 0);

    // Basic pattern, pixel 0 two cycles after load.
    drawing = 1'b1;
    load_at(8'h05, 3'd6, 3'd1, 1'b0, 1'b0, L);
    repeat (12) step();
    for (int k = 0; k < 8; k++) chk("t1_pixel", log0[L + 2 + k], t1e[k]);
    chk("t1_underrun_after_end", und0, 1);

    // Repeat 2, inverted solid row shows background for 16 cycles.
    do_reset();
    drawing = 1'b1;
    load_at(8'hFF, 3'd7, 3'd2, 1'b0, 1'b1, L);
    repeat (20) step();
    for (int k = 0; k < 16; k++) chk("t2_rep2_bg", log1[L + 2 + k], 2);

    // Back-to-back cells, then one omitted load.
    do_reset();
    drawing = 1'b1;
    for (int n = 0; n < 10; n++) begin
      load_at(8'hFF, 3'd4, 3'd3, 1'b0, 1'b0, L);
      if (n == 0) L0 = L;
      repeat (7) step();
    end
    repeat (8) step();
    load_at(8'hFF, 3'd4, 3'd3, 1'b0, 1'b0, L);
    repeat (4) step();
    for (int k = 2; k < 82; k++) chk("t3_seamless", log0[L0 + k], 4);
    chk("t3_no_underrun", logu[L0 + 80], 0);
    chk("t3_underrun_set", logu[L0 + 81], 1);
    for (int k = 82; k < 90; k++) chk("t3_gap_bg", log0[L0 + k], 3);
    chk("t3_resume", log0[L0 + 90], 4);
    chk("t3_underrun_sticky", und0, 1);

    // Blink timer with BLINK_FRAMES=4.
    do_reset();
    drawing = 1'b1;
    row_pixels = 8'hFF; foreground = 3'd5; background = 3'd2; blink = 1'b1;
    base = cyc;
    for (int k = 0; k < 90; k++) begin
      load = (k % 8) == 0;
      frame_start = (k % 10) == 5;
      step();
    end
    load = 1'b0; frame_start = 1'b0; blink = 1'b0;
    step();
    chk("t4_blink_on", logb[base + 20], 1);
    chk("t4_fg_visible", log0[base + 20], 5);
    chk("t4_blink_before_fall", logb[base + 35], 1);
    chk("t4_blink_fall", logb[base + 36], 0);
    chk("t4_last_fg", log0[base + 36], 5);
    chk("t4_first_bg", log0[base + 37], 2);
    chk("t4_bg_hidden", log0[base + 40], 2);
    chk("t4_blink_before_rise", logb[base + 75], 0);
    chk("t4_blink_rise", logb[base + 76], 1);
    chk("t4_fg_again", log0[base + 80], 5);

    // drawing=0 blanks and never flags underrun; reset mid-cell.
    do_reset();
    load_at(8'hFF, 3'd6, 3'd1, 1'b0, 1'b0, L);
    repeat (10) step();
    for (int k = 0; k < 8; k++) chk("t5_blank", log0[L + 2 + k], 0);
    chk("t5_no_underrun", und0, 0);
    drawing = 1'b1;
    load_at(8'h05, 3'd6, 3'd1, 1'b0, 1'b0, L);
    repeat (3) step();
    chk("t5_pixel2", dac0, 6);
    reset_button = 1'b0;
    #1;
    chk("t5_async_clear", dac0, 0);
    step();
    step();
    reset_button = 1'b1;
    repeat (4) step();
    chk("t5_idle_after_reset", dac0, 0);
    load_at(8'h05, 3'd6, 3'd1, 1'b0, 1'b0, L);
    repeat (3) step();
    chk("t5_pre_resume", log0[L + 1], 0);
    chk("t5_resume", log0[L + 2], 6);

`ifdef TEXT_PIXEL_CURSOR_EN
    do_reset();
    drawing = 1'b1;
    cursor = 1'b1;
    load_at(8'h01, 3'd5, 3'd2, 1'b0, 1'b0, L);
    repeat (10) step();
    chk("t6_cursor_px0", log0[L + 2], 2);
    for (int k = 1; k < 8; k++) chk("t6_cursor_px", log0[L + 2 + k], 5);
    chk("t6_cursor_exhausted", log0[L + 10], 5);
    frame_start = 1'b1; step(); frame_start = 1'b0; step();
    frame_start = 1'b1; step(); frame_start = 1'b0; step();
    load_at(8'h01, 3'd5, 3'd2, 1'b0, 1'b0, L);
    repeat (4) step();
    cursor = 1'b0;
    chk("t6_normal_px0", log0[L + 2], 5);
    chk("t6_normal_px1", log0[L + 3], 2);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
